// File: rtl/mem_arb_pkg.sv
// Shared constants and request bundle type for the data memory arbiter.
package mem_arb_pkg;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    localparam int MEM_DEPTH_DEF    = 256;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CW_DEF           = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the loader port has been denied.
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CW    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == CW'(LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of data_mem: CPU port has priority, loader port is
// protected from starvation; read data and range errors return one cycle later.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    mem_req_t    req_bus [2];
    logic [1:0]  req;
    logic [1:0]  gnt;
    mem_req_t    sel;
    logic        any_gnt;
    logic        in_range;
    logic        starve_sat;
    logic [1:0]  rvalid_p1;
    logic [1:0]  err_p1;
    logic [31:0] rdata_p1 [2];

    // Stage 0: arbitration and memory port drive
    always_comb begin
        req[PORT_CPU]     = p0_req;
        req[PORT_LDR]     = p1_req;
        req_bus[PORT_CPU] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
        req_bus[PORT_LDR] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

        gnt = 2'b00;
        if (!rst) begin
            if (req[PORT_LDR] && (!req[PORT_CPU] || starve_sat)) begin
                gnt[PORT_LDR] = 1'b1;
            end else if (req[PORT_CPU]) begin
                gnt[PORT_CPU] = 1'b1;
            end
        end

        sel       = gnt[PORT_LDR] ? req_bus[PORT_LDR] : req_bus[PORT_CPU];
        any_gnt   = |gnt;
        in_range  = ({2'b00, sel.addr[31:2]} < 32'(MEM_DEPTH));
        mem_read  = any_gnt && in_range && !sel.we;
        mem_write = any_gnt && in_range && sel.we;
        mem_addr  = any_gnt ? sel.addr : '0;
        mem_wdata = any_gnt ? sel.wdata : '0;
    end

    assign p0_gnt = gnt[PORT_CPU];
    assign p1_gnt = gnt[PORT_LDR];

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CW    (CW)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (p1_req && !gnt[PORT_LDR]),
        .clr (!p1_req || gnt[PORT_LDR]),
        .sat (starve_sat)
    );

    // Stage 1: registered read response and range error per port
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_p1   <= 2'b00;
            err_p1      <= 2'b00;
            rdata_p1[0] <= '0;
            rdata_p1[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_p1[i] <= gnt[i] && !sel.we;
                err_p1[i]    <= gnt[i] && !in_range;
                if (gnt[i] && !sel.we) begin
                    rdata_p1[i] <= in_range ? mem_rdata : '0;
                end
            end
        end
    end

    // Masking with rst drops a response already in flight when reset arrives.
    assign p0_rvalid = rvalid_p1[PORT_CPU] && !rst;
    assign p1_rvalid = rvalid_p1[PORT_LDR] && !rst;
    assign p0_err    = err_p1[PORT_CPU] && !rst;
    assign p1_err    = err_p1[PORT_LDR] && !rst;
    assign p0_rdata  = rst ? '0 : rdata_p1[PORT_CPU];
    assign p1_rdata  = rst ? '0 : rdata_p1[PORT_LDR];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;

    localparam int MEM_DEPTH    = 256;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_clr;
    logic [31:0] env_mem [MEM_DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_mem [MEM_DEPTH];
    logic        m_rvalid [2];
    logic        m_err    [2];
    logic [31:0] m_rdata  [2];
    int          m_starve;
    int          m_win;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem stand-in; a recognisable pattern replaces high-Z when not reading
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) env_mem[i] <= 32'h0;
        end else if (mem_write) begin
            env_mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? env_mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs this cycle with the model, then advance the model.
    task automatic check_cycle();
        logic [31:0] a, d;
        logic        we, oor;
        int          w;
        w = -1;
        if (!rst) begin
            if (p0_req && p1_req) w = (m_starve == STARVE_LIMIT) ? 1 : 0;
            else if (p0_req)      w = 0;
            else if (p1_req)      w = 1;
        end
        m_win = w;
        a   = (w == 1) ? p1_addr  : p0_addr;
        d   = (w == 1) ? p1_wdata : p0_wdata;
        we  = (w == 1) ? p1_we    : p0_we;
        oor = (a >> 2) >= MEM_DEPTH;

        chk("p0_gnt",    p0_gnt,    w == 0);
        chk("p1_gnt",    p1_gnt,    w == 1);
        chk("mem_read",  mem_read,  (w >= 0) && !oor && !we);
        chk("mem_write", mem_write, (w >= 0) && !oor && we);
        if (w < 0) begin
            chk("mem_addr_idle",  mem_addr,  32'h0);
            chk("mem_wdata_idle", mem_wdata, 32'h0);
        end else if (!oor) begin
            chk("mem_addr", mem_addr, a);
            if (we) chk("mem_wdata", mem_wdata, d);
        end
        chk("p0_rvalid", p0_rvalid, rst ? 1'b0 : m_rvalid[0]);
        chk("p0_err",    p0_err,    rst ? 1'b0 : m_err[0]);
        chk("p0_rdata",  p0_rdata,  rst ? 32'h0 : m_rdata[0]);
        chk("p1_rvalid", p1_rvalid, rst ? 1'b0 : m_rvalid[1]);
        chk("p1_err",    p1_err,    rst ? 1'b0 : m_err[1]);
        chk("p1_rdata",  p1_rdata,  rst ? 32'h0 : m_rdata[1]);

        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_rvalid[i] = 1'b0;
                m_err[i]    = 1'b0;
                m_rdata[i]  = 32'h0;
            end
            m_starve = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_rvalid[i] = (w == i) && !we;
                m_err[i]    = (w == i) && oor;
                if ((w == i) && !we) m_rdata[i] = oor ? 32'h0 : m_mem[a[9:2]];
            end
            if ((w >= 0) && we && !oor) m_mem[a[9:2]] = d;
            if (!p1_req || (w == 1)) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end
    endtask

    task automatic step(input logic r,
                        input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        mem_clr  = 1'b0;
        rst      = r;
        p0_req   = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req   = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        check_cycle();
    endtask

    function automatic logic [31:0] gen_addr();
        int idx;
        if ($urandom_range(0, 7) == 0) return 32'h400 + 32'($urandom_range(0, 4095));
        idx = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15));
        return (32'(idx) << 2) | 32'($urandom_range(0, 3));
    endfunction

    logic        pq0, pw0, pq1, pw1;
    logic [31:0] pa0, pd0, pa1, pd1;
    logic        rr;

    initial begin
        mem_clr = 1'b1;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            m_rvalid[i] = 1'b0; m_err[i] = 1'b0; m_rdata[i] = 32'h0;
        end
        m_starve = 0;
        m_win    = -1;

        // reset held with both ports requesting
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            chk("rst_p0_gnt",    p0_gnt,    1'b0);
            chk("rst_p1_gnt",    p1_gnt,    1'b0);
            chk("rst_mem_read",  mem_read,  1'b0);
            chk("rst_mem_write", mem_write, 1'b0);
            chk("rst_p0_rvalid", p0_rvalid, 1'b0);
            chk("rst_p1_err",    p1_err,    1'b0);
        end

        // write then read back on port 0
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        chk("wr_gnt",   p0_gnt,    1'b1);
        chk("wr_mem_w", mem_write, 1'b1);
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rd_mem_r", mem_read, 1'b1);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rd_rvalid", p0_rvalid, 1'b1);
        chk("rd_rdata",  p0_rdata,  32'hDEADBEEF);

        // continuous contention: loader wins only on the fifth cycle
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            chk("starve_p1_gnt", p1_gnt, k == 4);
            chk("starve_p0_gnt", p0_gnt, k != 4);
        end
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // loader read just past the end of memory
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h400, 32'h0);
        chk("oor_gnt",      p1_gnt,   1'b1);
        chk("oor_mem_read", mem_read, 1'b0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("oor_rvalid", p1_rvalid, 1'b1);
        chk("oor_err",    p1_err,    1'b1);
        chk("oor_rdata",  p1_rdata,  32'h0);

        // reset right after a read grant discards the response
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rstdrop_rvalid_a", p0_rvalid, 1'b0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rstdrop_rvalid_b", p0_rvalid, 1'b0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rstdrop_rvalid_c", p0_rvalid, 1'b0);

        // byte-offset bits are ignored
        step(0, 1, 1, 32'h13, 32'h1234, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("lowbits_rvalid", p0_rvalid, 1'b1);
        chk("lowbits_rdata",  p0_rdata,  32'h1234);

        // randomised traffic, requests held until granted
        pq0 = 0; pw0 = 0; pa0 = 0; pd0 = 0;
        pq1 = 0; pw1 = 0; pa1 = 0; pd1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pq0 && ($urandom_range(0, 3) != 0)) begin
                pq0 = 1; pw0 = 1'($urandom_range(0, 1)); pa0 = gen_addr(); pd0 = $urandom;
            end
            if (!pq1 && ($urandom_range(0, 2) == 0)) begin
                pq1 = 1; pw1 = 1'($urandom_range(0, 1)); pa1 = gen_addr(); pd1 = $urandom;
            end
            rr = ($urandom_range(0, 59) == 0);
            step(rr, pq0, pw0, pa0, pd0, pq1, pw1, pa1, pd1);
            if (m_win == 0) pq0 = 0;
            if (m_win == 1) pq1 = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
